vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator with pixel output stage. It sits between the system clock and the board VGA connector, driving HSYNC, VSYNC and 3-3-2 RGB. It exposes pixel coordinates so upstream pixel sources can compute colour one pixel ahead. It generalises the fixed 640x480 timing in `Main`: porch, sync, polarity and pixel-clock division are all configurable, and it adds frame and line strobes plus blanking-safe RGB gating.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 1, i_clk cycles per pixel (≥1)
- HSYNC_POL, 0, HSYNC asserted level
- VSYNC_POL, 0, VSYNC asserted level
- XW, 10, width of o_x; must hold H_ACTIVE+H_FP+H_SYNC+H_BP-1
- YW, 10, width of o_y; must hold V_ACTIVE+V_FP+V_SYNC+V_BP-1

- i_clk  in  1  system clock; the only clock
- i_reset  in  1  synchronous, active-high reset
- i_rgb  in  8  pixel colour {R[2:0],G[2:0],B[1:0]} for the pixel at o_x/o_y
- i_pattern  in  1  selects the test pattern (only under VGA_TEST_PATTERN_EN)
- o_pixel_en  out  1  one-i_clk pulse per pixel period
- o_x  out  XW  horizontal counter h
- o_y  out  YW  vertical counter v
- o_active  out  1  h<H_ACTIVE and v<V_ACTIVE
- o_line_start  out  1  pulse on the pixel_en with h==0
- o_frame_start  out  1  pulse on the pixel_en with h==0, v==0
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- o_Red  out  3  red
- o_Green  out  3  green
- o_Blue  out  2  blue

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - counts 0..CLK_DIV-1 and wraps.
  - o_pixel_en = 1 when the divider is at CLK_DIV-1.
  - CLK_DIV=1 gives o_pixel_en constantly 1 outside reset.
- Counters:
  - On o_pixel_en, h increments; at H_TOTAL-1, h wraps to 0.
  - v increments on an h wrap; at V_TOTAL-1 (with h wrapping), v wraps to 0.
- o_x, o_y, o_active, o_line_start and o_frame_start are decoded from the current h/v and are therefore request-side.
- Display side, registered on o_pixel_en:
  - HSYNC = HSYNC_POL while H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - VSYNC = VSYNC_POL while V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL.
  - RGB = o_active ? i_rgb : 0. RGB is forced to 0 outside the active area regardless of i_rgb.
- Reset (i_reset high at an i_clk edge):
  - divider, h and v go to 0.
  - o_pixel_en, o_active, o_line_start and o_frame_start are 0 while i_reset is high.
  - HSYNC = ~HSYNC_POL, VSYNC = ~VSYNC_POL, RGB = 0.
  - Reset mid-frame aborts the frame immediately; no partial sync pulse is held.

## Timing
- Request-to-display latency: exactly one pixel period. The colour sampled while o_x=n appears on RGB together with the HSYNC/VSYNC state for h=n.
- First o_pixel_en after reset release: the CLK_DIV-th i_clk edge after the edge that sees i_reset low. That pulse carries h=0, v=0, so o_frame_start=1.
- o_frame_start and o_line_start are coincident with o_pixel_en and last one i_clk.
- Outputs are stable between o_pixel_en pulses.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV i_clk cycles. Defaults: 420000.
- Simultaneous h wrap and v wrap are one event: the next state is (0,0), with o_frame_start asserted.
- i_rgb is sampled only on o_pixel_en edges with o_active=1.

## Configuration
- VGA_TEST_PATTERN_EN defined, and i_pattern=1:
  - i_rgb is ignored.
  - Active pixels show 8 vertical colour bars, bar index = o_x*8/H_ACTIVE. The colour is {3{idx[2]},3{idx[1]},2{idx[0]}}, i.e. white at bar 7 and black at bar 0.
  - Blanking rules are unchanged.
- VGA_TEST_PATTERN_EN undefined:
  - i_pattern is unused.
  - RGB always derives from i_rgb.

## Test plan
- Reset: hold i_reset for 5 clocks, defaults -> HSYNC=1, VSYNC=1, RGB=0, o_active=0, o_x=0, o_y=0 throughout. First pixel_en after release has o_frame_start=1.
- Line timing, CLK_DIV=1: measure HSYNC -> low for exactly 96 cycles, period 800 cycles, falling edge 657 cycles after o_line_start (656 + 1 latency).
- Frame timing: VSYNC low for exactly 2 lines (1600 cycles). o_frame_start period 420000 cycles. o_y reaches 524 then wraps to 0.
- Blanking: i_rgb=8'hFF constant -> RGB=0xFF only for 640 pixels per line on lines 0..479. RGB=0 in every porch/sync cycle.
- CLK_DIV=2, HSYNC_POL=1 -> o_pixel_en every 2nd clock, HSYNC high for 192 clocks, line period 1600 clocks.
- Mid-frame reset at v=200, h=300 -> next cycle h=v=0, syncs inactive. Full 420000-cycle frame follows. With VGA_TEST_PATTERN_EN and i_pattern=1: pixel x=0 -> 0x00, x=639 -> 0xFF.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered sync/RGB output stage.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern selected by i_pattern.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   CLK_DIV   = 1,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   XW        = 10,
  parameter int   YW        = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rgb,
  input  logic          i_pattern,
  output logic          o_pixel_en,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_active,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic [2:0]    o_Red,
  output logic [2:0]    o_Green,
  output logic [1:0]    o_Blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT        = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYNC_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT        = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYNC_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q;
  logic [XW-1:0] h_q;
  logic [YW-1:0] v_q;
  logic          pixel_en;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          in_hsync;
  logic          in_vsync;
  logic [7:0]    pix_src;
  logic [7:0]    rgb_q;
  logic          hsync_q;
  logic          vsync_q;

  // Request side is combinational so reset forces the strobes low in the same cycle.
  assign pixel_en = ~i_reset & (div_q == DIV_LAST);
  assign h_last   = (h_q == H_LAST);
  assign v_last   = (v_q == V_LAST);
  assign active   = ~i_reset & (h_q < H_ACT) & (v_q < V_ACT);
  assign in_hsync = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
  assign in_vsync = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pixel_en) begin
      if (h_last) begin
        h_q <= '0;
        v_q <= v_last ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [XW+2:0] BAR_DIV = (XW+3)'(H_ACTIVE);
  logic [2:0] bar_idx;

  // Bar index is only meaningful inside the active area; blanking masks the rest.
  assign bar_idx = 3'(({3'b000, h_q} << 3) / BAR_DIV);
  assign pix_src = i_pattern ? {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}} : i_rgb;
`else
  logic unused_pattern;
  assign unused_pattern = i_pattern;
  assign pix_src        = i_rgb;
`endif

  // Display side lags the request side by exactly one pixel period.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      rgb_q   <= '0;
    end else if (pixel_en) begin
      hsync_q <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
      rgb_q   <= active ? pix_src : '0;
    end
  end

  assign o_pixel_en    = pixel_en;
  assign o_x           = h_q;
  assign o_y           = v_q;
  assign o_active      = active;
  assign o_line_start  = pixel_en & (h_q == '0);
  assign o_frame_start = pixel_en & (h_q == '0) & (v_q == '0);
  assign HSYNC         = hsync_q;
  assign VSYNC         = vsync_q;
  assign o_Red         = rgb_q[7:5];
  assign o_Green       = rgb_q[4:2];
  assign o_Blue        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised self-checking bench for vga_timing_gen using a reduced raster (32x15, CLK_DIV=2).
// The reference model derives h/v from the count of pixel periods since reset.
module tb_vga_timing_gen;

  localparam int   HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int   VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int   DIV = 2;
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b0;
  localparam int   XW = 6, YW = 5;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FRAME = HT * VT * DIV;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [7:0]    i_rgb;
  logic          i_pattern;
  logic          o_pixel_en;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic          o_active;
  logic          o_line_start;
  logic          o_frame_start;
  logic          HSYNC;
  logic          VSYNC;
  logic [2:0]    o_Red;
  logic [2:0]    o_Green;
  logic [1:0]    o_Blue;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .XW(XW), .YW(YW)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rgb(i_rgb), .i_pattern(i_pattern),
    .o_pixel_en(o_pixel_en), .o_x(o_x), .o_y(o_y), .o_active(o_active),
    .o_line_start(o_line_start), .o_frame_start(o_frame_start),
    .HSYNC(HSYNC), .VSYNC(VSYNC),
    .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue)
  );

  always #5 i_clk = ~i_clk;

  int         checks_total  = 0;
  int         checks_passed = 0;
  int         cyc = 0;
  int         k = 0;
  logic       cur_reset = 1'b1;
  logic       exp_hs = ~HPOL;
  logic       exp_vs = ~VPOL;
  logic [7:0] exp_rgb = 8'h00;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [7:0] bar_colour(input int x);
    logic [2:0] b;
    b = 3'((x * 8) / HA);
    return {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkAll();
    int   p, h, v;
    logic pe, act;
    p   = k / DIV;
    h   = p % HT;
    v   = (p / HT) % VT;
    pe  = !cur_reset && (k % DIV == DIV - 1);
    act = !cur_reset && (h < HA) && (v < VA);
    checkOutput("pixel_en",    32'(o_pixel_en),    32'(pe));
    checkOutput("x",           32'(o_x),           32'(h));
    checkOutput("y",           32'(o_y),           32'(v));
    checkOutput("active",      32'(o_active),      32'(act));
    checkOutput("line_start",  32'(o_line_start),  32'(pe && h == 0));
    checkOutput("frame_start", 32'(o_frame_start), 32'(pe && h == 0 && v == 0));
    checkOutput("hsync",       32'(HSYNC),         32'(exp_hs));
    checkOutput("vsync",       32'(VSYNC),         32'(exp_vs));
    checkOutput("rgb",         32'({o_Red, o_Green, o_Blue}), 32'(exp_rgb));
  endtask

  // One clock: check at the falling edge, drive new inputs, then advance the model past the rising edge.
  task automatic doCycle(input logic rst);
    int         p, h, v;
    logic [7:0] rgb_drive, src;
    logic       pat_drive;
    @(negedge i_clk);
    checkAll();
    cyc++;
    rgb_drive = 8'($urandom);
    pat_drive = 1'($urandom);
    i_reset   = rst;
    i_rgb     = rgb_drive;
    i_pattern = pat_drive;
    if (rst) begin
      k       = 0;
      exp_hs  = ~HPOL;
      exp_vs  = ~VPOL;
      exp_rgb = 8'h00;
    end else begin
      if (k % DIV == DIV - 1) begin
        p   = k / DIV;
        h   = p % HT;
        v   = (p / HT) % VT;
        src = rgb_drive;
`ifdef VGA_TEST_PATTERN_EN
        if (pat_drive) src = bar_colour(h);
`endif
        exp_hs  = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
        exp_vs  = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
        exp_rgb = (h < HA && v < VA) ? src : 8'h00;
      end
      k++;
    end
    cur_reset = rst;
  endtask

  task automatic applyStimulus(input int n, input logic rst);
    for (int i = 0; i < n; i++) doCycle(rst);
  endtask

  // Aggregate timing over one frame, bounded so a stuck frame strobe still reaches the summary.
  task automatic measureFrame();
    int first = -1, second = -1, hs_cnt = 0, vs_cnt = 0;
    for (int i = 0; i < 3 * FRAME && second < 0; i++) begin
      doCycle(1'b0);
      if (o_frame_start === 1'b1) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
      if (first >= 0 && second < 0) begin
        if (HSYNC === HPOL) hs_cnt++;
        if (VSYNC === VPOL) vs_cnt++;
      end
    end
    checkOutput("frame_period", 32'(second - first), 32'(FRAME));
    checkOutput("hsync_cycles_per_frame", 32'(hs_cnt), 32'(HS * DIV * VT));
    checkOutput("vsync_cycles_per_frame", 32'(vs_cnt), 32'(VS * HT * DIV));
  endtask

  initial begin
    int fp, n;
    i_reset   = 1'b1;
    i_rgb     = 8'h00;
    i_pattern = 1'b0;
    repeat (2) @(posedge i_clk);

    applyStimulus(5, 1'b1);
    applyStimulus(2 * FRAME + 37, 1'b0);
    measureFrame();

    fp = k % FRAME;
    n  = (DIV * (5 * HT + 10) - fp + FRAME) % FRAME;
    if (n == 0) n = FRAME;
    applyStimulus(n, 1'b0);
    applyStimulus(1, 1'b1);
    applyStimulus(FRAME + 50, 1'b0);

    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom_range(20, 400), 1'b0);
      applyStimulus($urandom_range(1, 3), 1'b1);
    end
    applyStimulus(FRAME, 1'b0);
    measureFrame();

    @(negedge i_clk);
    checkAll();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
